// File: rtl/gate_bist_pkg.sv
// Shared types and reference truth tables for the gate BIST sequencer.
package gate_bist_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StApply,
    StDone
  } bist_state_t;

  localparam logic [3:0] AND2_TT  = 4'b1000;
  localparam logic [3:0] OR2_TT   = 4'b1110;
  localparam logic [3:0] XOR2_TT  = 4'b0110;
  localparam logic [3:0] NAND2_TT = 4'b0111;

endpackage

// File: rtl/gate_bist_timer.sv
// Settle counter: cleared by load, advances on tick, wraps after SETTLE-1 (flagged by last).
module gate_bist_timer #(
  parameter int unsigned SETTLE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic tick,
  output logic last
);

  localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] CntMax = CW'(SETTLE - 1);

  logic [CW-1:0] r_cnt;

  assign last = (r_cnt == CntMax);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= '0;
    end else if (tick) begin
      r_cnt <= last ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/gate_bist_ctrl.sv
// Exhaustive truth-table sequencer for a combinational gate under test.
// Define GATE_BIST_FAIL_LOG_EN to add first-mismatch logging outputs.
module gate_bist_ctrl
  import gate_bist_pkg::*;
#(
  parameter int unsigned               N_IN   = 2,
  parameter int unsigned               SETTLE = 2,
  parameter logic [(1 << N_IN) - 1:0]  EXP_TT = AND2_TT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [N_IN-1:0] dut_in,
  input  logic            dut_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   fail_cnt
`ifdef GATE_BIST_FAIL_LOG_EN
  ,
  output logic            first_fail_vld,
  output logic [N_IN-1:0] first_fail_idx
`endif
);

  localparam logic [N_IN-1:0] IdxMax = '1;

  bist_state_t r_state;
  logic        w_last;
  logic        w_load;
  logic        w_tick;
  logic        w_mismatch;
  logic [N_IN:0] w_fail_nxt;

  assign w_load = (r_state == StIdle) && start;
  assign w_tick = (r_state == StApply);

  // dut_in doubles as the pattern index; X/Z on the gate output counts as a mismatch
  assign w_mismatch = (dut_out !== EXP_TT[dut_in]);
  assign w_fail_nxt = fail_cnt + (N_IN + 1)'(w_mismatch);

  gate_bist_timer #(
    .SETTLE(SETTLE)
  ) u_timer (
    .clk (clk),
    .rst (rst),
    .load(w_load),
    .tick(w_tick),
    .last(w_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= StIdle;
      dut_in         <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      fail_cnt       <= '0;
`ifdef GATE_BIST_FAIL_LOG_EN
      first_fail_vld <= 1'b0;
      first_fail_idx <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (start) begin
            r_state        <= StApply;
            busy           <= 1'b1;
            dut_in         <= '0;
            fail_cnt       <= '0;
            pass           <= 1'b0;
`ifdef GATE_BIST_FAIL_LOG_EN
            first_fail_vld <= 1'b0;
            first_fail_idx <= '0;
`endif
          end
        end
        StApply: begin
          if (w_last) begin
            fail_cnt <= w_fail_nxt;
`ifdef GATE_BIST_FAIL_LOG_EN
            if (w_mismatch && !first_fail_vld) begin
              first_fail_vld <= 1'b1;
              first_fail_idx <= dut_in;
            end
`endif
            if (dut_in == IdxMax) begin
              r_state <= StDone;
              busy    <= 1'b0;
              done    <= 1'b1;
              pass    <= (w_fail_nxt == '0);
              dut_in  <= '0;
            end else begin
              dut_in <= dut_in + 1'b1;
            end
          end
        end
        StDone: r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Scoreboard bench for gate_bist_ctrl: AND2 defaults plus a 3-input, SETTLE=1 instance.
module tb_gate_bist_ctrl;

  localparam logic [3:0] AndTt = 4'b1000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       start3 = 1'b0;
  logic [1:0] dut_in;
  logic       dut_out;
  logic       busy, done, pass;
  logic [2:0] fail_cnt;
  logic [2:0] dut_in3;
  logic       dut_out3;
  logic       busy3, done3, pass3;
  logic [3:0] fail_cnt3;
`ifdef GATE_BIST_FAIL_LOG_EN
  logic       ffv, ffv3;
  logic [1:0] ffi;
  logic [2:0] ffi3;
`endif

  int mode = 0;  // 0: good AND2, 1: stuck-at-0, 2: stuck-at-1
  int errors = 0;
  int checks = 0;
  int busy_len = 0;
  logic [31:0] q_in[$];
  logic [31:0] q_res[$];
  logic [31:0] q_in3[$];

  always #5 clk = ~clk;

  assign dut_out  = (mode == 0) ? &dut_in : (mode == 2);
  assign dut_out3 = &dut_in3;

  gate_bist_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .dut_in(dut_in), .dut_out(dut_out),
    .busy(busy), .done(done), .pass(pass), .fail_cnt(fail_cnt)
`ifdef GATE_BIST_FAIL_LOG_EN
    , .first_fail_vld(ffv), .first_fail_idx(ffi)
`endif
  );

  gate_bist_ctrl #(.N_IN(3), .SETTLE(1), .EXP_TT(8'b1000_0000)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .dut_in(dut_in3), .dut_out(dut_out3),
    .busy(busy3), .done(done3), .pass(pass3), .fail_cnt(fail_cnt3)
`ifdef GATE_BIST_FAIL_LOG_EN
    , .first_fail_vld(ffv3), .first_fail_idx(ffi3)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic gate_model(input int m, input int idx);
    if (m == 0) return (idx == 3);
    return (m == 2);
  endfunction

  task automatic push_run(input int m);
    int fails = 0;
    for (int i = 0; i < 4; i++) begin
      q_in.push_back(32'(i));
      q_in.push_back(32'(i));
      if (gate_model(m, i) != AndTt[i]) fails++;
    end
    q_res.push_back({28'd0, 3'(fails), (fails == 0)});
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    if (!seen) check_eq({tag, "_timeout"}, 0, 1);
  endtask

  // Main-instance scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (busy) begin
        busy_len++;
        if (q_in.size() == 0) check_eq("extra_busy", 1, 0);
        else check_eq("dut_in", 32'(dut_in), q_in.pop_front());
      end else begin
        if (done) begin
          check_eq("busy_len", busy_len, 8);
          if (q_res.size() == 0) check_eq("unexpected_done", 1, 0);
          else check_eq("fail_cnt_pass", {28'd0, fail_cnt, pass}, q_res.pop_front());
        end
        busy_len = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && busy3) begin
      if (q_in3.size() == 0) check_eq("extra_busy3", 1, 0);
      else check_eq("dut_in3", 32'(dut_in3), q_in3.pop_front());
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_pass", pass, 0);
    check_eq("rst_fail_cnt", fail_cnt, 0);
    check_eq("rst_dut_in", dut_in, 0);
    rst = 1'b0;

    // Good AND2
    mode = 0; push_run(0); pulse_start(); wait_done("good");
    @(negedge clk);
    check_eq("good_pass_hold", pass, 1);
    check_eq("idle_dut_in", dut_in, 0);

    // Stuck-at-0
    mode = 1; push_run(1); pulse_start(); wait_done("sa0");
`ifdef GATE_BIST_FAIL_LOG_EN
    check_eq("sa0_ff_vld", ffv, 1);
    check_eq("sa0_ff_idx", ffi, 3);
`endif

    // Stuck-at-1
    mode = 2; push_run(2); pulse_start(); wait_done("sa1");
`ifdef GATE_BIST_FAIL_LOG_EN
    check_eq("sa1_ff_vld", ffv, 1);
    check_eq("sa1_ff_idx", ffi, 0);
`endif

    // Start held high: back-to-back runs with one idle cycle between them
    mode = 0; push_run(0); push_run(0);
    @(posedge clk); #1 start = 1'b1;
    wait_done("hold1");
    @(negedge clk);
    check_eq("hold_idle_gap", busy, 0);
    @(negedge clk);
    check_eq("hold_restart", busy, 1);
    #1 start = 1'b0;
    wait_done("hold2");
    repeat (5) @(negedge clk);
    check_eq("hold_no_third", busy, 0);
    check_eq("hold_q_empty", q_in.size() + q_res.size(), 0);

    // Reset mid-run
    mode = 2; push_run(2); pulse_start();
    for (int i = 0; i < 20 && !busy; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check_eq("mid_fail_cnt", fail_cnt, 1);
    #2 rst = 1'b1;
    #1;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_dut_in", dut_in, 0);
    check_eq("abort_fail_cnt", fail_cnt, 0);
    check_eq("abort_pass", pass, 0);
    check_eq("abort_done", done, 0);
    q_in.delete(); q_res.delete();
    @(posedge clk); #1 rst = 1'b0;
    repeat (15) @(negedge clk);
    mode = 0; push_run(0); pulse_start(); wait_done("after_rst");
    @(negedge clk);
    check_eq("after_rst_pass", pass, 1);

    // 3-input AND, SETTLE=1
    for (int i = 0; i < 8; i++) q_in3.push_back(32'(i));
    @(posedge clk); #1 start3 = 1'b1;
    @(posedge clk); #1 start3 = 1'b0;
    begin
      bit seen3 = 0;
      for (int i = 0; i < 50 && !seen3; i++) begin
        @(negedge clk);
        if (done3) seen3 = 1;
      end
      if (!seen3) check_eq("and3_timeout", 0, 1);
    end
    check_eq("and3_pass", pass3, 1);
    check_eq("and3_fail_cnt", fail_cnt3, 0);
    check_eq("and3_q_empty", q_in3.size(), 0);
    check_eq("final_q_empty", q_in.size() + q_res.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gate_bist_ctrl.md
# gate_bist_ctrl

Exhaustive truth-table sequencer for a combinational gate under test, such as the 2-input `andgate`. On a start request it drives every input pattern in ascending binary order and holds each one for a settle interval. It samples the gate output and compares it against an expected truth table, then reports pass/fail and a mismatch count. It sits between a test/host controller and one gate instance, which it owns exclusively while busy.

## Interface
Parameters:
- `N_IN`, default 2: number of gate inputs, 1..6.
- `SETTLE`, default 2: cycles each pattern is held, at least 1; the output is sampled on the last of these cycles.
- `EXP_TT`, default `4'b1000` (AND2): expected truth table, width 2^N_IN; bit i is the expected output for pattern i.

Ports:
- `clk` input 1: the single clock.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: run request; sampled only in IDLE.
- `dut_in` output N_IN: pattern driven to the gate; bit N_IN-1 is the MSB (for AND2, `{a,b}`).
- `dut_out` input 1: gate output.
- `busy` output 1: high while patterns are being applied.
- `done` output 1: one-cycle pulse at the end of a run.
- `pass` output 1: high when the last completed run had zero mismatches.
- `fail_cnt` output N_IN+1: mismatch count of the current or last run.

## Operation
- States:
  - IDLE: `busy`=0.
  - APPLY: `busy`=1.
  - DONE: `busy`=0, `done`=1.
- Transitions:
  - IDLE → APPLY when `start`=1. On entry, pattern index = 0, settle counter = 0 and `fail_cnt` = 0. `pass` is cleared to 0 at the same time.
  - In APPLY, `dut_in` equals the pattern index. The settle counter counts 0..SETTLE-1.
  - At counter = SETTLE-1, `dut_out` is compared with `EXP_TT[index]`. On a mismatch `fail_cnt` increments. Any non-0/1 value on `dut_out` counts as a mismatch. The index then increments and the counter returns to 0.
  - After the compare of index 2^N_IN-1, the FSM moves to DONE.
  - DONE → IDLE unconditionally after one cycle. On the DONE entry edge, `pass` is set to (final `fail_cnt` == 0).
- `start` is ignored in APPLY and DONE; it is not queued.
- `dut_in` returns to 0 in IDLE and DONE.
- `fail_cnt` never wraps, because its maximum 2^N_IN fits in N_IN+1 bits.
- `pass` and `fail_cnt` hold their values in IDLE until the next accepted `start`.

## Timing
- Reset values: state IDLE, `dut_in`=0, `busy`=0, `done`=0, `pass`=0, `fail_cnt`=0, all counters 0.
- Reset asserted mid-run aborts immediately and asynchronously. No `done` pulse is produced and no result is kept.
- Every output is a registered output.
- Run length: 2^N_IN × SETTLE cycles with `busy`=1. `done` rises on the next edge.
- Example with N_IN=2, SETTLE=2: `start` sampled at edge 0, `busy` high for edges 1–8, `done` high for one cycle after edge 9.
- `dut_out` is sampled at the edge that ends each pattern's final settle cycle. The gate therefore has SETTLE cycles minus setup to resolve.

## Configuration
- `GATE_BIST_FAIL_LOG_EN` defined: adds two outputs.
  - `first_fail_vld` (1 bit): set on the first mismatch of a run.
  - `first_fail_idx` (N_IN bits): latches the index of that first mismatch and holds it until the next accepted `start`.
  - Both outputs reset to 0 and are cleared when a run starts.
- `GATE_BIST_FAIL_LOG_EN` undefined: neither port nor the associated logic exists. All other behaviour is identical.

## Structure
- Package `gate_bist_pkg` contains:
  - state enum typedef `bist_state_t` (IDLE, APPLY, DONE);
  - truth-table constants `AND2_TT`=4'b1000, `OR2_TT`=4'b1110, `XOR2_TT`=4'b0110, `NAND2_TT`=4'b0111.
- One sub-module, `gate_bist_timer`: the settle counter with a `load`/`tick` interface and a `last` flag asserted when the count reaches SETTLE-1.

## Test plan
- Correct AND2 connected, defaults: pulse `start` → `dut_in` steps 0,1,2,3 for 2 cycles each; `done` after edge 9; `pass`=1, `fail_cnt`=0.
- `dut_out` stuck-at-0 → `fail_cnt`=1, `pass`=0; with the macro, `first_fail_idx`=3 and `first_fail_vld`=1.
- `dut_out` stuck-at-1 → `fail_cnt`=3, `pass`=0; `first_fail_idx`=0.
- `start` held high through a whole run, including the DONE cycle → exactly one run; the second run starts at the first IDLE cycle after DONE.
- `rst` asserted at cycle 4 of a run → all outputs 0 immediately and no `done` pulse; a new `start` then completes a full 8-cycle run with `pass`=1.
- N_IN=3, SETTLE=1, `EXP_TT`=8'b1000_0000 with a 3-input AND → 8 busy cycles, `pass`=1, `fail_cnt`=0.
